// File: rtl/xpb_table_gen.sv
// xpb_table_gen: builds entry[i] = (i * base) mod modulus at run time by
// successive modular addition, then serves NUM_PORTS registered lookups.
module xpb_table_gen #(
    parameter int unsigned DIGIT_W   = 5,
    parameter int unsigned WORD_W    = 1024,
    parameter int unsigned NUM_PORTS = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [WORD_W-1:0]             base_i,
    input  logic [WORD_W-1:0]             modulus_i,
    output logic                          busy,
    output logic                          ready,
    input  logic [NUM_PORTS*DIGIT_W-1:0]  lut_addr_i,
    output logic [NUM_PORTS*WORD_W-1:0]   lut_data_o
);

    localparam int unsigned DEPTH = 1 << DIGIT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        READY = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 load;
    logic                 gen_we;

    logic [WORD_W-1:0]    base_q;
    logic [WORD_W-1:0]    mod_q;
    logic [WORD_W-1:0]    acc;
    logic [DIGIT_W-1:0]   k;

    logic [WORD_W:0]      sum;
    logic [WORD_W:0]      mod_ext;
    logic [WORD_W-1:0]    nxt;

    logic [WORD_W-1:0]    entry  [DEPTH];
    logic [WORD_W-1:0]    data_q [NUM_PORTS];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode; start is only honoured outside GEN
    always_comb begin
        state_next = state;
        load       = 1'b0;
        gen_we     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = GEN;
                end
            end
            GEN: begin
                gen_we = 1'b1;
                if (k == DIGIT_W'(DEPTH - 1)) begin
                    state_next = READY;
                end
            end
            READY: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = GEN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Modular step: one full-width-plus-carry add, one subtract, one mux
    always_comb begin
        sum     = {1'b0, acc} + {1'b0, base_q};
        mod_ext = {1'b0, mod_q};
        if (sum >= mod_ext) begin
            nxt = WORD_W'(sum - mod_ext);
        end else begin
            nxt = sum[WORD_W-1:0];
        end
    end

    // Operand latch, accumulator and write index
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= '0;
            mod_q  <= '0;
            acc    <= '0;
            k      <= '0;
        end else if (load) begin
            base_q <= base_i;
            mod_q  <= modulus_i;
            acc    <= '0;
            k      <= DIGIT_W'(1);
        end else if (gen_we) begin
            acc    <= nxt;
            k      <= k + DIGIT_W'(1);
        end
    end

    // Table storage; contents are don't-care until regenerated
    always_ff @(posedge clk) begin
        if (load) begin
            entry[0] <= '0;
        end else if (gen_we) begin
            entry[k] <= nxt;
        end
    end

    // Status flags, registered from the current state
    always_ff @(posedge clk) begin
        if (reset) begin
            busy  <= 1'b0;
            ready <= 1'b0;
        end else begin
            busy  <= (state == GEN);
            ready <= (state == READY);
        end
    end

    // Independent registered lookup ports, gated by ready
    always_ff @(posedge clk) begin
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (reset || !ready) begin
                data_q[p] <= '0;
            end else begin
                data_q[p] <= entry[lut_addr_i[p*DIGIT_W +: DIGIT_W]];
            end
        end
    end

    // Pack per-port data onto the flat output bus
    always_comb begin
        lut_data_o = '0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            lut_data_o[p*WORD_W +: WORD_W] = data_q[p];
        end
    end

endmodule

// File: tb/tb_xpb_table_gen.sv
// Directed bench for xpb_table_gen: a small 8-bit instance and a default
// 1024-bit instance, checked against hand-computed tables and a golden model.
module tb_xpb_table_gen;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // Small instance: DIGIT_W=3, WORD_W=8
    logic         start_s;
    logic [7:0]   base_s;
    logic [7:0]   mod_s;
    logic         busy_s;
    logic         ready_s;
    logic [5:0]   addr_s;
    logic [15:0]  data_s;

    // Default instance: DIGIT_W=5, WORD_W=1024
    logic           start_b;
    logic [1023:0]  base_b;
    logic [1023:0]  mod_b;
    logic           busy_b;
    logic           ready_b;
    logic [9:0]     addr_b;
    logic [2047:0]  data_b;

    int passed = 0;
    int total  = 0;
    logic [7:0] exp8 [8];

    xpb_table_gen #(.DIGIT_W(3), .WORD_W(8), .NUM_PORTS(2)) dut_s (
        .clk        (clk),
        .reset      (reset),
        .start      (start_s),
        .base_i     (base_s),
        .modulus_i  (mod_s),
        .busy       (busy_s),
        .ready      (ready_s),
        .lut_addr_i (addr_s),
        .lut_data_o (data_s)
    );

    xpb_table_gen dut_b (
        .clk        (clk),
        .reset      (reset),
        .start      (start_b),
        .base_i     (base_b),
        .modulus_i  (mod_b),
        .busy       (busy_b),
        .ready      (ready_b),
        .lut_addr_i (addr_b),
        .lut_data_o (data_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    function automatic logic [1023:0] gold(input int i);
        logic [1031:0] p;
        p = 1032'(i) * {8'd0, base_b};
        return 1024'(p % {8'd0, mod_b});
    endfunction

    // Start the small instance and wait for ready; optionally pulse start during GEN
    task automatic run_small(input string tag, input logic [7:0] b, input logic [7:0] m, input bit pulse);
        int n;
        base_s  = b;
        mod_s   = m;
        start_s = 1'b1;
        tick;
        start_s = 1'b0;
        base_s  = 8'hAA;
        mod_s   = 8'hF0;
        tick;
        check({tag, "_busy"}, 1024'(busy_s), 1024'(1));
        check({tag, "_ready_low"}, 1024'(ready_s), 1024'(0));
        n = 1;
        while (!ready_s && n < 100) begin
            start_s = pulse && (n < 5) && (n % 2 == 1);
            tick;
            n++;
        end
        start_s = 1'b0;
        check({tag, "_latency"}, 1024'(n), 1024'(8));
        check({tag, "_busy_done"}, 1024'(busy_s), 1024'(0));
    endtask

    // Sweep all addresses, port1 in reverse order
    task automatic sweep_small(input string tag);
        for (int a = 0; a < 8; a++) begin
            addr_s = {3'(7 - a), 3'(a)};
            tick;
            check($sformatf("%s_p0_a%0d", tag, a), 1024'(data_s[7:0]), 1024'(exp8[a]));
            check($sformatf("%s_p1_a%0d", tag, 7 - a), 1024'(data_s[15:8]), 1024'(exp8[7 - a]));
        end
    endtask

    initial begin
        int n;
        reset   = 1'b1;
        start_s = 1'b0;
        base_s  = '0;
        mod_s   = 8'd1;
        addr_s  = '0;
        start_b = 1'b0;
        base_b  = '0;
        mod_b   = 1024'd1;
        addr_b  = '0;
        tick;
        tick;
        check("rst_busy_s", 1024'(busy_s), 1024'(0));
        check("rst_ready_s", 1024'(ready_s), 1024'(0));
        check("rst_data_s", 1024'(data_s), 1024'(0));
        check("rst_busy_b", 1024'(busy_b), 1024'(0));
        check("rst_ready_b", 1024'(ready_b), 1024'(0));
        check("rst_data_b", data_b[1023:0] | data_b[2047:1024], 1024'(0));
        reset = 1'b0;
        tick;

        // Basic table, base=100 mod 251
        run_small("s1", 8'd100, 8'd251, 1'b0);
        exp8 = '{8'd0, 8'd100, 8'd200, 8'd49, 8'd149, 8'd249, 8'd98, 8'd198};
        sweep_small("s1");

        // Carry/wrap edge from READY: 9-bit sum must not truncate
        run_small("carry", 8'd250, 8'd251, 1'b0);
        exp8 = '{8'd0, 8'd250, 8'd249, 8'd248, 8'd247, 8'd246, 8'd245, 8'd244};
        sweep_small("carry");

        // Exact-modulus edge: sum == modulus folds to 0
        run_small("exact", 8'd100, 8'd200, 1'b0);
        exp8 = '{8'd0, 8'd100, 8'd0, 8'd100, 8'd0, 8'd100, 8'd0, 8'd100};
        sweep_small("exact");

        // Restart with start pulses during GEN that must be ignored
        run_small("restart", 8'd7, 8'd251, 1'b1);
        exp8 = '{8'd0, 8'd7, 8'd14, 8'd21, 8'd28, 8'd35, 8'd42, 8'd49};
        sweep_small("restart");

        // Reset during GEN, then regenerate the first table
        base_s  = 8'd250;
        mod_s   = 8'd251;
        start_s = 1'b1;
        tick;
        start_s = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("mid_rst_busy", 1024'(busy_s), 1024'(0));
        check("mid_rst_ready", 1024'(ready_s), 1024'(0));
        check("mid_rst_data", 1024'(data_s), 1024'(0));
        tick;
        check("mid_rst_idle_busy", 1024'(busy_s), 1024'(0));
        run_small("post_rst", 8'd100, 8'd251, 1'b0);
        exp8 = '{8'd0, 8'd100, 8'd200, 8'd49, 8'd149, 8'd249, 8'd98, 8'd198};
        sweep_small("post_rst");

        // Default-parameter instance with a full-width modulus
        mod_b   = {32{32'hFFFF_FFF1}};
        base_b  = {32{32'hDEAD_BEEF}};
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        addr_b  = {5'd2, 5'd1};
        n = 0;
        while (!ready_b && n < 200) begin
            tick;
            n++;
            if (!ready_b && n <= 3) begin
                check($sformatf("big_busy_p0_c%0d", n), data_b[1023:0], 1024'(0));
                check($sformatf("big_busy_p1_c%0d", n), data_b[2047:1024], 1024'(0));
            end
        end
        check("big_latency", 1024'(n), 1024'(32));
        check("big_busy_done", 1024'(busy_b), 1024'(0));
        addr_b = {5'd1, 5'd1};
        tick;
        check("big_entry1_base", data_b[1023:0], base_b);
        for (int a = 0; a < 32; a++) begin
            addr_b = {5'(31 - a), 5'(a)};
            tick;
            check($sformatf("big_p0_a%0d", a), data_b[1023:0], gold(a));
            check($sformatf("big_p1_a%0d", 31 - a), data_b[2047:1024], gold(31 - a));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
